mem_wb_stage: RTL and testbench

- MEM/WB pipeline register of the 32-bit pipelined core.
- Captures the ALU result, register-file destination and raw data-memory read word from the memory stage.
- Performs registered load byte/halfword extraction with sign/zero extension, and flags misaligned or illegal loads.
- Its outputs feed the writeback 2:1 select: wb_alu_result is input a, wb_load_data is input b, wb_mem_to_reg is select_b.

---
 rtl/mem_wb_stage.sv | 140 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// mem_wb_stage - MEM/WB pipeline register of the 32-bit pipelined core.
//
// Captures the ALU result, destination register and raw data-memory word
// from the memory stage, extracts and extends the load value, and flags
// misaligned or reserved-funct3 loads. All outputs are registered.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   stall, flush      hold stage / kill the entry being captured (flush wins)
//   ex_valid          memory-stage entry is a real instruction
//   ex_alu_result     ALU result, also the load address
//   ex_rd             destination register
//   ex_reg_write      instruction writes rd
//   ex_mem_to_reg     instruction is a load
//   ex_funct3         load type (LB/LH/LW/LBU/LHU)
//   mem_rdata         word-aligned data-memory read word
//   wb_valid          stage holds a live instruction
//   wb_alu_result     registered ALU result (writeback mux input a)
//   wb_load_data      extracted/extended load value (writeback mux input b)
//   wb_mem_to_reg     writeback select, 1 picks load data
//   wb_rd             destination register
//   wb_reg_write      final register-file write enable
//   wb_misaligned     load address misaligned for its size
//   wb_illegal        load with reserved funct3
//   wb_retire_count   count of valid entries captured (wraps silently)
module mem_wb_stage #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  ex_valid,
    input  logic [XLEN-1:0]       ex_alu_result,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_reg_write,
    input  logic                  ex_mem_to_reg,
    input  logic [2:0]            ex_funct3,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  wb_valid,
    output logic [XLEN-1:0]       wb_alu_result,
    output logic [XLEN-1:0]       wb_load_data,
    output logic                  wb_mem_to_reg,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic                  wb_reg_write,
    output logic                  wb_misaligned,
    output logic                  wb_illegal,
    output logic [31:0]           wb_retire_count
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    logic [1:0]      addr_lo;
    logic [7:0]      byte_sel;
    logic [15:0]     half_sel;
    logic [XLEN-1:0] ext_data;
    logic            funct3_ok;
    logic            is_load;
    logic            misaligned;
    logic            illegal;
    logic [XLEN-1:0] load_next;
    logic            reg_write_next;

    assign addr_lo = ex_alu_result[1:0];

    always_comb begin
        byte_sel  = '0;
        half_sel  = '0;
        ext_data  = '0;
        funct3_ok = 1'b1;

        case (addr_lo)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        case (ex_funct3)
            F3_LB:   ext_data = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            F3_LBU:  ext_data = {{(XLEN-8){1'b0}}, byte_sel};
            F3_LH:   ext_data = {{(XLEN-16){half_sel[15]}}, half_sel};
            F3_LHU:  ext_data = {{(XLEN-16){1'b0}}, half_sel};
            F3_LW:   ext_data = mem_rdata;
            default: begin
                ext_data  = '0;
                funct3_ok = 1'b0;
            end
        endcase

        // Fault flags only qualify live loads; a bubble never reports a fault.
        is_load    = ex_valid & ex_mem_to_reg;
        misaligned = is_load &
                     ((((ex_funct3 == F3_LH) || (ex_funct3 == F3_LHU)) && addr_lo[0]) ||
                      ((ex_funct3 == F3_LW) && (addr_lo != 2'd0)));
        illegal    = is_load & ~funct3_ok;

        load_next = (ex_mem_to_reg && !misaligned && !illegal) ? ext_data : '0;

        reg_write_next = ex_valid & ex_reg_write & (ex_rd != '0) &
                         ~misaligned & ~illegal;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid        <= 1'b0;
            wb_alu_result   <= '0;
            wb_load_data    <= '0;
            wb_mem_to_reg   <= 1'b0;
            wb_rd           <= '0;
            wb_reg_write    <= 1'b0;
            wb_misaligned   <= 1'b0;
            wb_illegal      <= 1'b0;
            wb_retire_count <= '0;
        end else if (flush) begin
            // Kill only the control side; data fields keep their old values.
            wb_valid      <= 1'b0;
            wb_reg_write  <= 1'b0;
            wb_misaligned <= 1'b0;
            wb_illegal    <= 1'b0;
        end else if (!stall) begin
            wb_valid        <= ex_valid;
            wb_alu_result   <= ex_alu_result;
            wb_load_data    <= load_next;
            wb_mem_to_reg   <= ex_mem_to_reg;
            wb_rd           <= ex_rd;
            wb_reg_write    <= reg_write_next;
            wb_misaligned   <= misaligned;
            wb_illegal      <= illegal;
            wb_retire_count <= wb_retire_count + {31'd0, ex_valid};
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        flush;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        ex_mem_to_reg;
    logic [2:0]  ex_funct3;
    logic [31:0] mem_rdata;
    logic        wb_valid;
    logic [31:0] wb_alu_result;
    logic [31:0] wb_load_data;
    logic        wb_mem_to_reg;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        wb_misaligned;
    logic        wb_illegal;
    logic [31:0] wb_retire_count;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Expected stage contents maintained by the reference model.
    logic        e_valid, e_mtr, e_rw, e_mis, e_ill;
    logic [31:0] e_alu, e_ld, e_cnt;
    logic [4:0]  e_rd;

    always #5 clk = ~clk;

    mem_wb_stage #(.XLEN(32), .REG_ADDR_W(5)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_to_reg(ex_mem_to_reg),
        .ex_funct3(ex_funct3), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_alu_result(wb_alu_result),
        .wb_load_data(wb_load_data), .wb_mem_to_reg(wb_mem_to_reg),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_misaligned(wb_misaligned), .wb_illegal(wb_illegal),
        .wb_retire_count(wb_retire_count)
    );

    task automatic model_reset();
        e_valid = 0; e_mtr = 0; e_rw = 0; e_mis = 0; e_ill = 0;
        e_alu = 0; e_ld = 0; e_cnt = 0; e_rd = 0;
    endtask

    // Next-state of the stage computed from the load rules with plain arithmetic.
    task automatic model_step();
        int unsigned size, shift, off;
        bit          sgn, legal, live_load, mis, ill;
        longint unsigned mask, val;
        off = ex_alu_result % 4;
        legal = 1; sgn = 0; size = 4; shift = 0;
        case (ex_funct3)
            3'd0: begin size = 1; sgn = 1; shift = off * 8; end
            3'd4: begin size = 1; sgn = 0; shift = off * 8; end
            3'd1: begin size = 2; sgn = 1; shift = (off / 2) * 16; end
            3'd5: begin size = 2; sgn = 0; shift = (off / 2) * 16; end
            3'd2: begin size = 4; sgn = 0; shift = 0; end
            default: legal = 0;
        endcase
        live_load = ex_valid && ex_mem_to_reg;
        ill = live_load && !legal;
        mis = live_load && legal && ((ex_alu_result % size) != 0);
        mask = (64'd1 << (size * 8)) - 1;
        val  = (64'(mem_rdata) >> shift) & mask;
        if (sgn && val >= ((mask + 1) / 2)) val = val + (64'hFFFF_FFFF - mask);
        if (!ex_mem_to_reg || !legal || mis || ill) val = 0;

        if (flush) begin
            e_valid = 0; e_rw = 0; e_mis = 0; e_ill = 0;
        end else if (!stall) begin
            e_valid = ex_valid;
            e_alu   = ex_alu_result;
            e_rd    = ex_rd;
            e_mtr   = ex_mem_to_reg;
            e_ld    = val[31:0];
            e_mis   = mis;
            e_ill   = ill;
            e_rw    = ex_valid && ex_reg_write && (ex_rd != 0) && !mis && !ill;
            if (ex_valid) e_cnt = e_cnt + 1;
        end
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input bit v, input logic [31:0] a, input logic [4:0] rd,
                         input bit rw, input bit mtr, input logic [2:0] f3,
                         input logic [31:0] rdata);
        ex_valid = v; ex_alu_result = a; ex_rd = rd; ex_reg_write = rw;
        ex_mem_to_reg = mtr; ex_funct3 = f3; mem_rdata = rdata;
    endtask

    task automatic test_reset();
        rst_n = 0; stall = 0; flush = 0;
        drive(1, 32'hFFFF_FFFF, 5'd31, 1, 1, 3'd2, 32'hFFFF_FFFF);
        @(negedge clk); @(negedge clk);
        model_reset();
        n_checks++;
        if ({wb_valid, wb_alu_result, wb_load_data, wb_mem_to_reg, wb_rd, wb_reg_write,
             wb_misaligned, wb_illegal, wb_retire_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b alu=%h ld=%h mtr=%b rd=%0d rw=%b mis=%b ill=%b cnt=%h, expected all zero",
                     wb_valid, wb_alu_result, wb_load_data, wb_mem_to_reg, wb_rd,
                     wb_reg_write, wb_misaligned, wb_illegal, wb_retire_count);
        end
        rst_n = 1;
        drive(0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
    endtask

    task automatic test_capture();
        drive(1, 32'h1234, 5'd7, 1, 0, 3'd0, 32'hDEAD_BEEF);
        step();
        n_checks++; if (wb_alu_result !== 32'h1234) begin n_fail++; $display("FAIL capture_alu: got %h expected %h", wb_alu_result, 32'h1234); end
        n_checks++; if (wb_rd !== 5'd7) begin n_fail++; $display("FAIL capture_rd: got %0d expected 7", wb_rd); end
        n_checks++; if (wb_reg_write !== 1'b1) begin n_fail++; $display("FAIL capture_rw: got %b expected 1", wb_reg_write); end
        n_checks++; if (wb_load_data !== 32'h0) begin n_fail++; $display("FAIL capture_ld: got %h expected 0", wb_load_data); end
        n_checks++; if (wb_retire_count !== 32'd1) begin n_fail++; $display("FAIL capture_cnt: got %0d expected 1", wb_retire_count); end
        n_checks++; if (wb_valid !== 1'b1) begin n_fail++; $display("FAIL capture_valid: got %b expected 1", wb_valid); end
    endtask

    task automatic test_loads();
        logic [2:0]  f3  [5] = '{3'd0, 3'd4, 3'd1, 3'd5, 3'd2};
        logic [1:0]  ofs [5] = '{2'd3, 2'd3, 2'd2, 2'd0, 2'd0};
        logic [31:0] exp [5] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80F1,
                                 32'h0000_7F82, 32'h80F1_7F82};
        for (int i = 0; i < 5; i++) begin
            drive(1, 32'h0000_2000 | 32'(ofs[i]), 5'd5, 1, 1, f3[i], 32'h80F1_7F82);
            step();
            n_checks++;
            if (wb_load_data !== exp[i] || wb_misaligned !== 1'b0 || wb_reg_write !== 1'b1) begin
                n_fail++;
                $display("FAIL load_%0d: got ld=%h mis=%b rw=%b expected ld=%h mis=0 rw=1",
                         i, wb_load_data, wb_misaligned, wb_reg_write, exp[i]);
            end
        end
        n_checks++; if (wb_retire_count !== e_cnt) begin n_fail++; $display("FAIL load_cnt: got %0d expected %0d", wb_retire_count, e_cnt); end
    endtask

    task automatic test_faults();
        drive(1, 32'h0000_2001, 5'd6, 1, 1, 3'd1, 32'h80F1_7F82);
        step();
        n_checks++;
        if (wb_misaligned !== 1'b1 || wb_reg_write !== 1'b0 || wb_load_data !== 32'h0 || wb_illegal !== 1'b0) begin
            n_fail++;
            $display("FAIL misaligned_lh: got mis=%b rw=%b ld=%h ill=%b expected mis=1 rw=0 ld=0 ill=0",
                     wb_misaligned, wb_reg_write, wb_load_data, wb_illegal);
        end
        drive(1, 32'h0000_2000, 5'd6, 1, 1, 3'd3, 32'h80F1_7F82);
        step();
        n_checks++;
        if (wb_illegal !== 1'b1 || wb_reg_write !== 1'b0 || wb_load_data !== 32'h0) begin
            n_fail++;
            $display("FAIL illegal_f3: got ill=%b rw=%b ld=%h expected ill=1 rw=0 ld=0",
                     wb_illegal, wb_reg_write, wb_load_data);
        end
    endtask

    task automatic test_stall_flush();
        logic [31:0] cnt0;
        drive(1, 32'h0000_CAFE, 5'd9, 1, 0, 3'd0, 0);
        step();
        cnt0 = e_cnt;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            drive(1, $urandom, 5'(i + 20), 1, 1, 3'd2, $urandom);
            step();
            n_checks++;
            if (wb_alu_result !== 32'h0000_CAFE || wb_rd !== 5'd9 || wb_valid !== 1'b1 ||
                wb_reg_write !== 1'b1 || wb_retire_count !== cnt0) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: got alu=%h rd=%0d v=%b rw=%b cnt=%0d expected alu=0000cafe rd=9 v=1 rw=1 cnt=%0d",
                         i, wb_alu_result, wb_rd, wb_valid, wb_reg_write, wb_retire_count, cnt0);
            end
        end
        flush = 1;
        step();
        n_checks++;
        if (wb_valid !== 1'b0 || wb_reg_write !== 1'b0 || wb_retire_count !== cnt0 ||
            wb_alu_result !== 32'h0000_CAFE) begin
            n_fail++;
            $display("FAIL flush_stall: got v=%b rw=%b cnt=%0d alu=%h expected v=0 rw=0 cnt=%0d alu=0000cafe",
                     wb_valid, wb_reg_write, wb_retire_count, wb_alu_result, cnt0);
        end
        stall = 0; flush = 0;
    endtask

    task automatic test_rd_zero();
        logic [31:0] cnt0;
        cnt0 = e_cnt;
        drive(1, 32'h55, 5'd0, 1, 0, 3'd0, 0);
        step();
        n_checks++;
        if (wb_reg_write !== 1'b0 || wb_retire_count !== cnt0 + 1) begin
            n_fail++;
            $display("FAIL rd_zero: got rw=%b cnt=%0d expected rw=0 cnt=%0d", wb_reg_write, wb_retire_count, cnt0 + 1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            stall = ($urandom_range(9) < 2);
            flush = ($urandom_range(9) < 1);
            drive($urandom_range(7) != 0, $urandom, ($urandom_range(5) == 0) ? 5'd0 : 5'($urandom),
                  $urandom_range(1), $urandom_range(1), 3'($urandom), $urandom);
            step();
            n_checks++;
            if (wb_valid !== e_valid || wb_alu_result !== e_alu || wb_load_data !== e_ld ||
                wb_mem_to_reg !== e_mtr || wb_rd !== e_rd || wb_reg_write !== e_rw ||
                wb_misaligned !== e_mis || wb_illegal !== e_ill || wb_retire_count !== e_cnt) begin
                n_fail++;
                $display("FAIL random_%0d: got v=%b alu=%h ld=%h mtr=%b rd=%0d rw=%b mis=%b ill=%b cnt=%0d expected v=%b alu=%h ld=%h mtr=%b rd=%0d rw=%b mis=%b ill=%b cnt=%0d",
                         i, wb_valid, wb_alu_result, wb_load_data, wb_mem_to_reg, wb_rd, wb_reg_write,
                         wb_misaligned, wb_illegal, wb_retire_count,
                         e_valid, e_alu, e_ld, e_mtr, e_rd, e_rw, e_mis, e_ill, e_cnt);
            end
        end
        stall = 0; flush = 0;
    endtask

    task automatic test_wrap();
        force dut.wb_retire_count = 32'hFFFF_FFFF;
        #1;
        release dut.wb_retire_count;
        e_cnt = 32'hFFFF_FFFF;
        drive(1, 32'h77, 5'd3, 1, 0, 3'd0, 0);
        step();
        n_checks++;
        if (wb_retire_count !== 32'h0) begin
            n_fail++;
            $display("FAIL counter_wrap: got %h expected 00000000", wb_retire_count);
        end
    endtask

    task automatic test_async_reset();
        drive(1, 32'h0000_2002, 5'd12, 1, 1, 3'd5, 32'h80F1_7F82);
        step();
        stall = 1; flush = 1;
        #2 rst_n = 0;
        #1;
        n_checks++;
        if ({wb_valid, wb_alu_result, wb_load_data, wb_mem_to_reg, wb_rd, wb_reg_write,
             wb_misaligned, wb_illegal, wb_retire_count} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got v=%b alu=%h ld=%h mtr=%b rd=%0d rw=%b mis=%b ill=%b cnt=%h expected all zero",
                     wb_valid, wb_alu_result, wb_load_data, wb_mem_to_reg, wb_rd,
                     wb_reg_write, wb_misaligned, wb_illegal, wb_retire_count);
        end
        @(negedge clk);
        rst_n = 1; stall = 0; flush = 0;
        model_reset();
    endtask

    initial begin
        test_reset();
        test_capture();
        test_loads();
        test_faults();
        test_stall_flush();
        test_rd_zero();
        test_random();
        test_wrap();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
